// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode width and opcode encodings used by the ALU
// and by every block that issues operations to it.
package alu_pkg;

    localparam int ALU_OP_W = 7;

    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam alu_op_t ALU_ADD  = 7'd1;
    localparam alu_op_t ALU_SUB  = 7'd2;
    localparam alu_op_t ALU_SLL  = 7'd3;
    localparam alu_op_t ALU_SRL  = 7'd4;
    localparam alu_op_t ALU_SRA  = 7'd5;
    localparam alu_op_t ALU_AND  = 7'd6;
    localparam alu_op_t ALU_OR   = 7'd7;
    localparam alu_op_t ALU_XOR  = 7'd8;
    localparam alu_op_t ALU_EQ   = 7'd9;
    localparam alu_op_t ALU_NE   = 7'd10;
    localparam alu_op_t ALU_SLTU = 7'd11;
    localparam alu_op_t ALU_SLT  = 7'd12;

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit ALU; unknown opcodes produce zero.
module alu
    import alu_pkg::*;
(
    input  logic [ALU_OP_W-1:0] op,
    input  logic [31:0]         a,
    input  logic [31:0]         b,
    output logic [31:0]         y
);

    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic        [4:0]  shamt;

    assign a_s   = a;
    assign b_s   = b;
    assign shamt = b[4:0];

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << shamt;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = a_s >>> shamt;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_EQ:   y = {31'b0, a == b};
            ALU_NE:   y = {31'b0, a != b};
            ALU_SLTU: y = {31'b0, a < b};
            ALU_SLT:  y = {31'b0, a_s < b_s};
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared ALU, with a single
// registered result slot and saturating per-requester grant counters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                rdy_in,

    input  logic                r0_valid,
    output logic                r0_ready,
    input  logic [ALU_OP_W-1:0] r0_op,
    input  logic [31:0]         r0_a,
    input  logic [31:0]         r0_b,
    input  logic [TAG_W-1:0]    r0_tag,

    input  logic                r1_valid,
    output logic                r1_ready,
    input  logic [ALU_OP_W-1:0] r1_op,
    input  logic [31:0]         r1_a,
    input  logic [31:0]         r1_b,
    input  logic [TAG_W-1:0]    r1_tag,

    output logic                res_valid,
    input  logic                res_ready,
    output logic [31:0]         res_data,
    output logic [TAG_W-1:0]    res_tag,
    output logic                res_src,
    output logic                res_bad_op,

    output logic [CNT_W-1:0]    grant_cnt0,
    output logic [CNT_W-1:0]    grant_cnt1
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic                vld_p1;
    logic [31:0]         data_p1;
    logic [TAG_W-1:0]    tag_p1;
    logic                src_p1;
    logic                bad_p1;
    logic                prio;
    logic [CNT_W-1:0]    cnt0;
    logic [CNT_W-1:0]    cnt1;

    logic                slot_free_p0;
    logic                accept_en_p0;
    logic                gnt0_p0;
    logic                gnt1_p0;
    logic                accept_p0;
    logic [ALU_OP_W-1:0] op_p0;
    logic [31:0]         a_p0;
    logic [31:0]         b_p0;
    logic [TAG_W-1:0]    tag_p0;
    logic                bad_op_p0;
    logic [31:0]         alu_y_p0;

    // Stage 0: arbitration and operand select (combinational)
    assign slot_free_p0 = !vld_p1 || res_ready;
    assign accept_en_p0 = rst_n_in && rdy_in && slot_free_p0;
    assign gnt0_p0      = accept_en_p0 && r0_valid && (!r1_valid || !prio);
    assign gnt1_p0      = accept_en_p0 && r1_valid && (!r0_valid || prio);
    assign accept_p0    = gnt0_p0 || gnt1_p0;

    assign op_p0  = gnt1_p0 ? r1_op  : r0_op;
    assign a_p0   = gnt1_p0 ? r1_a   : r0_a;
    assign b_p0   = gnt1_p0 ? r1_b   : r0_b;
    assign tag_p0 = gnt1_p0 ? r1_tag : r0_tag;

    assign bad_op_p0 = (op_p0 == '0) || (op_p0 > ALU_SLT);

    alu u_alu (
        .op (op_p0),
        .a  (a_p0),
        .b  (b_p0),
        .y  (alu_y_p0)
    );

    // Stage 1: result slot, round-robin pointer and counters
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            tag_p1  <= '0;
            src_p1  <= 1'b0;
            bad_p1  <= 1'b0;
            prio    <= 1'b0;
            cnt0    <= '0;
            cnt1    <= '0;
        end else if (rdy_in) begin
            if (accept_p0) begin
                vld_p1  <= 1'b1;
                data_p1 <= bad_op_p0 ? 32'd0 : alu_y_p0;
                tag_p1  <= tag_p0;
                src_p1  <= gnt1_p0;
                bad_p1  <= bad_op_p0;
                // Next tie goes to whoever lost this time.
                prio    <= !gnt1_p0;
                if (gnt0_p0) cnt0 <= sat_inc(cnt0);
                if (gnt1_p0) cnt1 <= sat_inc(cnt1);
            end else if (res_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign r0_ready   = gnt0_p0;
    assign r1_ready   = gnt1_p0;
    assign res_valid  = vld_p1;
    assign res_data   = data_p1;
    assign res_tag    = tag_p1;
    assign res_src    = src_p1;
    assign res_bad_op = bad_p1;
    assign grant_cnt0 = cnt0;
    assign grant_cnt1 = cnt1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed table-driven bench for alu_arbiter plus a saturation sequence on a
// narrow-counter instance.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rdy;
    logic        r0_valid, r0_ready, r1_valid, r1_ready;
    logic [6:0]  r0_op, r1_op;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;
    logic [3:0]  r0_tag, r1_tag;
    logic        res_valid, res_ready, res_src, res_bad_op;
    logic [31:0] res_data;
    logic [3:0]  res_tag;
    logic [15:0] cnt0, cnt1;

    alu_arbiter #(.TAG_W(4), .CNT_W(16)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op),
        .r0_a(r0_a), .r0_b(r0_b), .r0_tag(r0_tag),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op),
        .r1_a(r1_a), .r1_b(r1_b), .r1_tag(r1_tag),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .res_src(res_src), .res_bad_op(res_bad_op),
        .grant_cnt0(cnt0), .grant_cnt1(cnt1)
    );

    // Narrow-counter instance for saturation
    logic        s_rst_n, s_r0_valid, s_r0_ready, s_r1_ready;
    logic        s_res_valid, s_res_src, s_res_bad_op;
    logic [31:0] s_res_data;
    logic [3:0]  s_res_tag;
    logic [1:0]  s_cnt0, s_cnt1;

    alu_arbiter #(.TAG_W(4), .CNT_W(2)) dut_sat (
        .clk_in(clk), .rst_n_in(s_rst_n), .rdy_in(1'b1),
        .r0_valid(s_r0_valid), .r0_ready(s_r0_ready), .r0_op(7'd1),
        .r0_a(32'd1), .r0_b(32'd1), .r0_tag(4'd0),
        .r1_valid(1'b0), .r1_ready(s_r1_ready), .r1_op(7'd1),
        .r1_a(32'd0), .r1_b(32'd0), .r1_tag(4'd0),
        .res_valid(s_res_valid), .res_ready(1'b1), .res_data(s_res_data),
        .res_tag(s_res_tag), .res_src(s_res_src), .res_bad_op(s_res_bad_op),
        .grant_cnt0(s_cnt0), .grant_cnt1(s_cnt1)
    );

    typedef struct {
        logic        rst_n, rdy;
        logic        v0;
        logic [6:0]  op0;
        logic [31:0] a0, b0;
        logic [3:0]  t0;
        logic        v1;
        logic [6:0]  op1;
        logic [31:0] a1, b1;
        logic [3:0]  t1;
        logic        rres;
        logic        e_rdy0, e_rdy1, e_vld;
        logic [31:0] e_data;
        logic [3:0]  e_tag;
        logic        e_src, e_bad;
        logic [15:0] e_c0, e_c1;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic add(input vec_t v);
        vq.push_back(v);
    endtask

    localparam logic [31:0] NEG = 32'h8000_0000;
    localparam logic [31:0] ALL = 32'hFFFF_FFFF;
    localparam logic [31:0] SRA = 32'hF800_0000;

    initial begin
        //      rst rdy v0 op0  a0      b0     t0  v1 op1 a1     b1     t1  rres | r0 r1 vld data    tag src bad c0  c1
        add('{0,  1,  1, 7'd1, 5,     7,      3,  0, 0,  0,     0,     0,  1,    0, 0, 0, 0,      0, 0, 0, 0,  0}); // 0 reset
        add('{0,  1,  1, 7'd1, 5,     7,      3,  0, 0,  0,     0,     0,  1,    0, 0, 0, 0,      0, 0, 0, 0,  0}); // 1 reset
        add('{1,  1,  1, 7'd1, 5,     7,      3,  0, 0,  0,     0,     0,  1,    1, 0, 1, 12,     3, 0, 0, 1,  0}); // 2 add
        add('{0,  1,  1, 7'd2, 10,    3,      1,  1, 5,  NEG,   4,     2,  1,    0, 0, 0, 0,      0, 0, 0, 0,  0}); // 3 reset w/ result
        add('{1,  1,  1, 7'd2, 10,    3,      1,  1, 5,  NEG,   4,     2,  1,    1, 0, 1, 7,      1, 0, 0, 1,  0}); // 4 rr r0
        add('{1,  1,  1, 7'd2, 10,    3,      1,  1, 5,  NEG,   4,     2,  1,    0, 1, 1, SRA,    2, 1, 0, 1,  1}); // 5 rr r1
        add('{1,  1,  1, 7'd2, 10,    3,      1,  1, 5,  NEG,   4,     2,  1,    1, 0, 1, 7,      1, 0, 0, 2,  1}); // 6
        add('{1,  1,  1, 7'd2, 10,    3,      1,  1, 5,  NEG,   4,     2,  1,    0, 1, 1, SRA,    2, 1, 0, 2,  2}); // 7
        add('{1,  0,  1, 7'd2, 10,    3,      1,  1, 5,  NEG,   4,     2,  1,    0, 0, 1, SRA,    2, 1, 0, 2,  2}); // 8 freeze
        add('{1,  0,  1, 7'd2, 10,    3,      1,  1, 5,  NEG,   4,     2,  1,    0, 0, 1, SRA,    2, 1, 0, 2,  2}); // 9 freeze
        add('{1,  1,  1, 7'd2, 10,    3,      1,  1, 5,  NEG,   4,     2,  1,    1, 0, 1, 7,      1, 0, 0, 3,  2}); // 10 resume
        add('{1,  1,  1, 7'd12, ALL,  0,      5,  0, 0,  0,     0,     0,  1,    1, 0, 1, 1,      5, 0, 0, 4,  2}); // 11 slt
        add('{1,  1,  0, 7'd0, 0,     0,      0,  1, 1,  100,   23,    6,  0,    0, 0, 1, 1,      5, 0, 0, 4,  2}); // 12 stall
        add('{1,  1,  0, 7'd0, 0,     0,      0,  1, 8,  32'hF0, 32'hFF, 7, 0,    0, 0, 1, 1,      5, 0, 0, 4,  2}); // 13 stall
        add('{1,  1,  0, 7'd0, 0,     0,      0,  1, 1,  100,   23,    6,  0,    0, 0, 1, 1,      5, 0, 0, 4,  2}); // 14 stall
        add('{1,  1,  0, 7'd0, 0,     0,      0,  1, 1,  100,   23,    6,  1,    0, 1, 1, 123,    6, 1, 0, 4,  3}); // 15 release
        add('{1,  1,  1, 7'd0, 5,     5,      1,  0, 0,  0,     0,     0,  1,    1, 0, 1, 0,      1, 0, 1, 5,  3}); // 16 op 0
        add('{1,  1,  1, 7'd13, 5,    5,      2,  0, 0,  0,     0,     0,  1,    1, 0, 1, 0,      2, 0, 1, 6,  3}); // 17 op 13
        add('{1,  1,  1, 7'd9, 4,     4,      3,  0, 0,  0,     0,     0,  1,    1, 0, 1, 1,      3, 0, 0, 7,  3}); // 18 eq
        add('{1,  1,  0, 7'd0, 0,     0,      0,  1, 3,  1,     32'h24, 4, 1,    0, 1, 1, 32'h10, 4, 1, 0, 7,  4}); // 19 sll
        add('{1,  1,  0, 7'd0, 0,     0,      0,  1, 4,  NEG,   32'h1F, 5, 1,    0, 1, 1, 1,      5, 1, 0, 7,  5}); // 20 srl
        add('{1,  1,  1, 7'd6, 32'hF0F0, 32'hFF00, 6, 0, 0, 0, 0,   0,  1,    1, 0, 1, 32'hF000, 6, 0, 0, 8, 5}); // 21 and
        add('{1,  1,  1, 7'd7, 32'hF0, 32'h0F, 7, 0, 0,  0,     0,     0,  1,    1, 0, 1, 32'hFF, 7, 0, 0, 9,  5}); // 22 or
        add('{1,  1,  1, 7'd8, 32'hFF, 32'h0F, 8, 0, 0,  0,     0,     0,  1,    1, 0, 1, 32'hF0, 8, 0, 0, 10, 5}); // 23 xor
        add('{1,  1,  1, 7'd10, 3,    4,      9,  0, 0,  0,     0,     0,  1,    1, 0, 1, 1,      9, 0, 0, 11, 5}); // 24 ne
        add('{1,  1,  1, 7'd11, ALL,  0,      10, 0, 0,  0,     0,     0,  1,    1, 0, 1, 0,      10, 0, 0, 12, 5}); // 25 sltu
        add('{1,  1,  1, 7'd12, NEG,  1,      11, 0, 0,  0,     0,     0,  1,    1, 0, 1, 1,      11, 0, 0, 13, 5}); // 26 slt
        add('{1,  1,  0, 7'd0, 0,     0,      0,  0, 0,  0,     0,     0,  1,    0, 0, 0, 1,      11, 0, 0, 13, 5}); // 27 drain

        s_rst_n = 1'b0;
        s_r0_valid = 1'b0;
        #1;
        foreach (vq[i]) begin
            rst_n = vq[i].rst_n; rdy = vq[i].rdy; res_ready = vq[i].rres;
            r0_valid = vq[i].v0; r0_op = vq[i].op0; r0_a = vq[i].a0; r0_b = vq[i].b0; r0_tag = vq[i].t0;
            r1_valid = vq[i].v1; r1_op = vq[i].op1; r1_a = vq[i].a1; r1_b = vq[i].b1; r1_tag = vq[i].t1;
            @(negedge clk);
            check($sformatf("v%0d r0_ready", i), 32'(r0_ready), 32'(vq[i].e_rdy0));
            check($sformatf("v%0d r1_ready", i), 32'(r1_ready), 32'(vq[i].e_rdy1));
            @(posedge clk);
            #1;
            check($sformatf("v%0d res_valid", i), 32'(res_valid), 32'(vq[i].e_vld));
            check($sformatf("v%0d res_data", i), res_data, vq[i].e_data);
            check($sformatf("v%0d res_tag", i), 32'(res_tag), 32'(vq[i].e_tag));
            check($sformatf("v%0d res_src", i), 32'(res_src), 32'(vq[i].e_src));
            check($sformatf("v%0d res_bad_op", i), 32'(res_bad_op), 32'(vq[i].e_bad));
            check($sformatf("v%0d grant_cnt0", i), 32'(cnt0), 32'(vq[i].e_c0));
            check($sformatf("v%0d grant_cnt1", i), 32'(cnt1), 32'(vq[i].e_c1));
        end

        // Counter saturation on the 2-bit instance
        @(posedge clk);
        #1;
        check("sat reset cnt0", 32'(s_cnt0), 32'd0);
        s_rst_n = 1'b1;
        s_r0_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("sat r0_ready %0d", k), 32'(s_r0_ready), 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("sat cnt0 after %0d", k), 32'(s_cnt0), (k > 3) ? 32'd3 : 32'(k));
        end
        s_r0_valid = 1'b0;
        @(posedge clk);
        #1;
        check("sat cnt0 hold", 32'(s_cnt0), 32'd3);
        check("sat res_valid drained", 32'(s_res_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
